// File: rtl/spu_cache_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spu_cache_pkg: shared SPU cache geometry, grant record and pointer helper
// Rev 1.0
// ----------------------------------------------------------------------------
package spu_cache_pkg;

  localparam int DATA_WIDTH = 1024;
  localparam int DATA_DEPTH = 9;
  localparam int NUM_REQ    = 4;
  localparam int ID_W       = 2;
  localparam int ID_W_MAX   = 3;

  // Wide enough for the largest legal requester count (8).
  typedef struct packed {
    logic                valid;
    logic                we;
    logic [ID_W_MAX-1:0] id;
  } grant_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spu_rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spu_rr_pick: first eligible requester at or after ptr, modulo N
// Rev 1.0
// ----------------------------------------------------------------------------
module spu_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [N-1:0] w_elig;

  assign w_elig = req & mask;

  always_comb begin
    int j;
    j     = 0;
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && w_elig[j]) begin
        found   = 1'b1;
        pick[j] = 1'b1;
        idx     = IW'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spu_cache_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spu_cache_arbiter: round-robin two-port grant onto the dual-port SPU cache
// Rev 1.0
// ----------------------------------------------------------------------------
module spu_cache_arbiter #(
  parameter int NUM_REQ    = spu_cache_pkg::NUM_REQ,
  parameter int DATA_WIDTH = spu_cache_pkg::DATA_WIDTH,
  parameter int DATA_DEPTH = spu_cache_pkg::DATA_DEPTH,
  parameter int ID_W       = spu_cache_pkg::ID_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*DATA_DEPTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic                             rsp_a_valid,
  output logic [ID_W-1:0]                  rsp_a_id,
  output logic [DATA_WIDTH-1:0]            rsp_a_data,
  output logic                             rsp_b_valid,
  output logic [ID_W-1:0]                  rsp_b_id,
  output logic [DATA_WIDTH-1:0]            rsp_b_data,
  output logic                             cache_wea,
  output logic                             cache_web,
  output logic [DATA_DEPTH-1:0]            cache_addra,
  output logic [DATA_DEPTH-1:0]            cache_addrb,
  output logic [DATA_WIDTH-1:0]            cache_dina,
  output logic [DATA_WIDTH-1:0]            cache_dinb,
  input  logic [DATA_WIDTH-1:0]            cache_douta,
  input  logic [DATA_WIDTH-1:0]            cache_doutb
);

  import spu_cache_pkg::*;

  logic [DATA_DEPTH-1:0] w_addr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_wdata [NUM_REQ];
  logic [NUM_REQ-1:0]    w_haz, w_pick_a, w_pick_b, w_mask_b;
  logic [ID_W-1:0]       w_idx_a, w_idx_b;
  logic                  w_found_a, w_found_b;
  grant_t                w_gnt_a, w_gnt_b;
  logic [ID_W-1:0]       r_rr_ptr;
  grant_t                r_tag_a, r_tag_b;
  logic                  w_unused_tag;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_addr[gi]  = req_addr[gi*DATA_DEPTH +: DATA_DEPTH];
      assign w_wdata[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      // Same address as the A winner with a write on either side cannot share the cycle.
      assign w_haz[gi]   = (w_addr[gi] == w_addr[w_idx_a]) && (req_we[gi] || req_we[w_idx_a]);
    end
  endgenerate

  spu_rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick_a (
    .req   (req_valid),
    .mask  ({NUM_REQ{1'b1}}),
    .ptr   (r_rr_ptr),
    .pick  (w_pick_a),
    .idx   (w_idx_a),
    .found (w_found_a)
  );

  assign w_mask_b = ~w_pick_a & ~w_haz;

  spu_rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick_b (
    .req   (req_valid),
    .mask  (w_mask_b),
    .ptr   (r_rr_ptr),
    .pick  (w_pick_b),
    .idx   (w_idx_b),
    .found (w_found_b)
  );

  always_comb begin
    w_gnt_a = '0;
    w_gnt_b = '0;
    if (!rst) begin
      w_gnt_a.valid = w_found_a;
      w_gnt_a.we    = w_found_a & req_we[w_idx_a];
      w_gnt_a.id    = ID_W_MAX'(w_idx_a);
      w_gnt_b.valid = w_found_b;
      w_gnt_b.we    = w_found_b & req_we[w_idx_b];
      w_gnt_b.id    = ID_W_MAX'(w_idx_b);
    end
  end

  assign req_ready   = rst ? '0 : (w_pick_a | w_pick_b);

  assign cache_wea   = w_gnt_a.we;
  assign cache_addra = w_gnt_a.valid ? w_addr[w_idx_a]  : '0;
  assign cache_dina  = w_gnt_a.valid ? w_wdata[w_idx_a] : '0;
  assign cache_web   = w_gnt_b.we;
  assign cache_addrb = w_gnt_b.valid ? w_addr[w_idx_b]  : '0;
  assign cache_dinb  = w_gnt_b.valid ? w_wdata[w_idx_b] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_tag_a  <= '0;
      r_tag_b  <= '0;
    end else begin
      r_tag_a.valid <= w_gnt_a.valid & ~w_gnt_a.we;
      r_tag_a.we    <= w_gnt_a.we;
      r_tag_a.id    <= w_gnt_a.id;
      r_tag_b.valid <= w_gnt_b.valid & ~w_gnt_b.we;
      r_tag_b.we    <= w_gnt_b.we;
      r_tag_b.id    <= w_gnt_b.id;
      // B is always later in scan order than A, so it is the last grant when present.
      if (w_gnt_b.valid)
        r_rr_ptr <= ID_W'(rr_next(int'(w_idx_b), NUM_REQ));
      else if (w_gnt_a.valid)
        r_rr_ptr <= ID_W'(rr_next(int'(w_idx_a), NUM_REQ));
    end
  end

  assign rsp_a_valid  = r_tag_a.valid;
  assign rsp_a_id     = r_tag_a.id[ID_W-1:0];
  assign rsp_a_data   = cache_douta;
  assign rsp_b_valid  = r_tag_b.valid;
  assign rsp_b_id     = r_tag_b.id[ID_W-1:0];
  assign rsp_b_data   = cache_doutb;

  assign w_unused_tag = ^{r_tag_a.we, r_tag_a.id, r_tag_b.we, r_tag_b.id};

endmodule
`default_nettype wire

// File: tb/tb_spu_cache_arbiter.sv
`default_nettype none
// tb_spu_cache_arbiter: directed grants checked at issue time, read responses
// checked by a scoreboard monitor against a bench-side shadow of the cache contents.
module tb_spu_cache_arbiter;

  localparam int N  = 4;
  localparam int DW = 1024;
  localparam int AW = 9;
  localparam int IW = 2;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    vld, we, req_ready;
  logic [AW-1:0]   a   [N];
  logic [DW-1:0]   wd  [N];
  logic [AW-1:0]   sa  [N];
  logic [DW-1:0]   swd [N];
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic            rsp_a_valid, rsp_b_valid;
  logic [IW-1:0]   rsp_a_id, rsp_b_id;
  logic [DW-1:0]   rsp_a_data, rsp_b_data;
  logic            cache_wea, cache_web;
  logic [AW-1:0]   cache_addra, cache_addrb;
  logic [DW-1:0]   cache_dina, cache_dinb, douta, doutb;

  logic [DW-1:0]   mem    [512];
  logic [DW-1:0]   shadow [512];
  logic            ram_loaded = 1'b0;
  exp_t            qa[$];
  exp_t            qb[$];
  int              total = 0;
  int              bad   = 0;

  assign req_addr  = {a[3], a[2], a[1], a[0]};
  assign req_wdata = {wd[3], wd[2], wd[1], wd[0]};

  always #5 clk = ~clk;

  spu_cache_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(vld), .req_ready(req_ready), .req_we(we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_a_valid(rsp_a_valid), .rsp_a_id(rsp_a_id), .rsp_a_data(rsp_a_data),
    .rsp_b_valid(rsp_b_valid), .rsp_b_id(rsp_b_id), .rsp_b_data(rsp_b_data),
    .cache_wea(cache_wea), .cache_web(cache_web),
    .cache_addra(cache_addra), .cache_addrb(cache_addrb),
    .cache_dina(cache_dina), .cache_dinb(cache_dinb),
    .cache_douta(douta), .cache_doutb(doutb)
  );

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] w;
    w = 32'(i) ^ 32'h5A00_0000;
    return {32{w}};
  endfunction

  // Dual-port RAM with registered read; a write cycle returns zero on that port.
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 512; i++) mem[i] <= pat(i);
      ram_loaded <= 1'b1;
    end else begin
      if (cache_wea) begin mem[cache_addra] <= cache_dina; douta <= '0; end
      else douta <= mem[cache_addra];
      if (cache_web) begin mem[cache_addrb] <= cache_dinb; doutb <= '0; end
      else doutb <= mem[cache_addrb];
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act[127:0], exp[127:0]);
    end
  endtask

  // One request cycle: apply staged addr/data, check grants and cache drive, queue expected reads.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] w, input logic [N-1:0] rdy,
                      input int ga, input int gb, input string nm);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin a[i] = sa[i]; wd[i] = swd[i]; end
    vld = v;
    we  = w;
    #3;
    chk({nm, " ready"}, req_ready, rdy);
    if (ga >= 0) begin
      chk({nm, " addra"}, cache_addra, a[ga]);
      chk({nm, " wea"}, cache_wea, w[ga]);
    end else begin
      chk({nm, " idle addra"}, cache_addra, 0);
      chk({nm, " idle wea"}, cache_wea, 0);
    end
    if (gb >= 0) begin
      chk({nm, " addrb"}, cache_addrb, a[gb]);
      chk({nm, " web"}, cache_web, w[gb]);
    end else begin
      chk({nm, " idle addrb"}, cache_addrb, 0);
      chk({nm, " idle web"}, cache_web, 0);
    end
    if (ga >= 0 && !w[ga]) qa.push_back('{ga, shadow[a[ga]]});
    if (gb >= 0 && !w[gb]) qb.push_back('{gb, shadow[a[gb]]});
    if (ga >= 0 && w[ga]) shadow[a[ga]] = wd[ga];
    if (gb >= 0 && w[gb]) shadow[a[gb]] = wd[gb];
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_a_valid) begin
        if (qa.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_a unexpected: id=%0d", rsp_a_id);
        end else begin
          e = qa.pop_front();
          chk("rsp_a id", rsp_a_id, e.id);
          chk("rsp_a data", rsp_a_data, e.data);
        end
      end
      if (rsp_b_valid) begin
        if (qb.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_b unexpected: id=%0d", rsp_b_id);
        end else begin
          e = qb.pop_front();
          chk("rsp_b id", rsp_b_id, e.id);
          chk("rsp_b data", rsp_b_data, e.data);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) shadow[i] = pat(i);
    for (int i = 0; i < N; i++) begin
      a[i] = AW'(i + 1); wd[i] = '0; sa[i] = '0; swd[i] = '0;
    end
    vld = 4'b1111;
    we  = 4'b0000;
    #2;
    chk("rst ready", req_ready, 0);
    chk("rst wea", cache_wea, 0);
    chk("rst addra", cache_addra, 0);
    chk("rst rsp_a_valid", rsp_a_valid, 0);
    chk("rst rsp_b_valid", rsp_b_valid, 0);
    chk("rst rsp ids", {rsp_a_id, rsp_b_id}, 0);
    chk("rst rr_ptr", dut.r_rr_ptr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    vld = '0;

    // Four readers, distinct addresses: pairs alternate (0,1) then (2,3).
    sa[0] = 9'h011; sa[1] = 9'h022; sa[2] = 9'h033; sa[3] = 9'h044;
    step(4'b1111, 4'b0000, 4'b0011, 0, 1, "all0");
    step(4'b1111, 4'b0000, 4'b1100, 2, 3, "all1");
    step(4'b1111, 4'b0000, 4'b0011, 0, 1, "all2");
    step(4'b1111, 4'b0000, 4'b1100, 2, 3, "all3");

    sa[1] = 9'h005;
    step(4'b0010, 4'b0000, 4'b0010, 1, -1, "single");

    sa[2] = 9'h1FF; sa[3] = 9'h1FF;
    step(4'b1100, 4'b0000, 4'b1100, 2, 3, "rdrd");

    sa[0] = 9'h010; sa[1] = 9'h010; swd[0] = {32{32'hDEAD_BEEF}};
    step(4'b0011, 4'b0001, 4'b0001, 0, -1, "wr_hz");
    step(4'b0010, 4'b0000, 4'b0010, 1, -1, "rd_new");

    sa[2] = 9'h000; swd[2] = {128{8'hA5}};
    step(4'b0100, 4'b0100, 4'b0100, 2, -1, "wrA5");
    sa[3] = 9'h050; sa[0] = 9'h000;
    step(4'b1001, 4'b0000, 4'b1001, 3, 0, "rdA5b");

    sa[1] = 9'h020; swd[1] = {32{32'h1234_5678}}; sa[2] = 9'h020; sa[3] = 9'h030;
    step(4'b1110, 4'b0010, 4'b1010, 1, 3, "skip");
    step(4'b0100, 4'b0000, 4'b0100, 2, -1, "rd_skip");

    sa[3] = 9'h060; sa[0] = 9'h060; swd[0] = {32{32'hFFFF_0000}}; sa[1] = 9'h070;
    step(4'b1011, 4'b0001, 4'b1010, 3, 1, "cand_wr");

    step(4'b0001, 4'b0000, 4'b0001, 0, -1, "pre_rst");
    step(4'b0000, 4'b0000, 4'b0000, -1, -1, "drain");

    @(posedge clk); #1;
    rst  = 1'b1;
    a[0] = 9'h008;
    vld  = 4'b0001;
    we   = 4'b0000;
    #3;
    chk("in_rst ready", req_ready, 0);
    chk("in_rst rr_ptr", dut.r_rr_ptr, 0);
    chk("in_rst wea", cache_wea, 0);
    chk("in_rst addra", cache_addra, 0);
    chk("in_rst rsp_a_valid", rsp_a_valid, 0);
    @(posedge clk); #1;
    rst  = 1'b0;
    a[0] = 9'h007;
    #3;
    chk("post_rst ready", req_ready, 4'b0001);
    chk("post_rst addra", cache_addra, 9'h007);
    qa.push_back('{0, shadow[7]});
    sa[0] = 9'h007;
    step(4'b0000, 4'b0000, 4'b0000, -1, -1, "tail0");
    step(4'b0000, 4'b0000, 4'b0000, -1, -1, "tail1");
    @(posedge clk); #4;
    chk("qa drained", qa.size(), 0);
    chk("qb drained", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
